// File: rtl/start_pkg.sv
// Shared types and constants for the start-screen countdown sequencer.
package start_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    GO    = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [3:0] BLANK_CODE = 4'd0;
  localparam logic [3:0] GO_CODE    = 4'hF;

  function automatic int unsigned max_uint(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Modulo counter with synchronous clear, count enable and a terminal-count pulse
// asserted on the last enabled cycle of each 0..limit-1 period.
module tick_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             terminal
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  assign terminal = enable && !clear && (count == (limit - ONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      if (terminal) begin
        count <= '0;
      end else begin
        count <= count + ONE;
      end
    end
  end

endmodule

// File: rtl/start_sequencer.sv
// 3-2-1-GO countdown driving the start-screen glyph code, then hands off to gameplay.
// Optional START_SEQ_PAUSE_EN adds a pause input that freezes COUNT/GO.
module start_sequencer
  import start_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = 50_000_000,
  parameter int unsigned GO_TICKS       = 50_000_000,
  parameter int unsigned COUNT_FROM     = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic       game_over,
`ifdef START_SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] STARTpos,
  output logic       busy,
  output logic       game_active,
  output logic       go_pulse,
  output logic       step_pulse
);

  localparam int unsigned CW = $clog2(max_uint(TICKS_PER_STEP, GO_TICKS) + 1);
  localparam logic [CW-1:0] STEP_LIM  = CW'(TICKS_PER_STEP);
  localparam logic [CW-1:0] GO_LIM    = CW'(GO_TICKS);
  localparam logic [1:0]    FIRST_DIG = 2'(COUNT_FROM);

  state_t     state, next_state;
  logic [1:0] digit, next_digit;
  logic       frozen;
  logic       cnt_clear, cnt_enable, cnt_tc;
  logic [CW-1:0] cnt_limit;

  logic [3:0] startpos_d;
  logic       busy_d, game_active_d, go_pulse_d, step_pulse_d;

`ifdef START_SEQ_PAUSE_EN
  assign frozen = pause;
`else
  assign frozen = 1'b0;
`endif

  // Counter only runs while a digit or GO is on screen; abort resets it with the FSM.
  assign cnt_clear  = abort || (state == IDLE) || (state == RUN);
  assign cnt_enable = ((state == COUNT) || (state == GO)) && !frozen;
  assign cnt_limit  = (state == GO) ? GO_LIM : STEP_LIM;

  tick_counter #(
    .WIDTH(CW)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .enable  (cnt_enable),
    .limit   (cnt_limit),
    .terminal(cnt_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      digit <= '0;
    end else begin
      state <= next_state;
      digit <= next_digit;
    end
  end

  always_comb begin
    next_state = state;
    next_digit = digit;
    if (abort) begin
      next_state = IDLE;
      next_digit = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            next_state = COUNT;
            next_digit = FIRST_DIG;
          end
        end
        COUNT: begin
          if (cnt_tc) begin
            if (digit == 2'd1) begin
              next_state = GO;
              next_digit = '0;
            end else begin
              next_digit = digit - 2'd1;
            end
          end
        end
        GO: begin
          if (cnt_tc) next_state = RUN;
        end
        RUN: begin
          if (game_over) next_state = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are registered, so their next values are decoded from next_state.
  always_comb begin
    unique case (next_state)
      COUNT:   startpos_d = {2'b00, next_digit};
      GO:      startpos_d = GO_CODE;
      default: startpos_d = BLANK_CODE;
    endcase
    busy_d        = (next_state == COUNT) || (next_state == GO);
    game_active_d = (next_state == RUN);
    go_pulse_d    = (next_state == RUN) && (state != RUN);
    step_pulse_d  = (startpos_d != BLANK_CODE) && (startpos_d != STARTpos);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      STARTpos    <= BLANK_CODE;
      busy        <= 1'b0;
      game_active <= 1'b0;
      go_pulse    <= 1'b0;
      step_pulse  <= 1'b0;
    end else begin
      STARTpos    <= startpos_d;
      busy        <= busy_d;
      game_active <= game_active_d;
      go_pulse    <= go_pulse_d;
      step_pulse  <= step_pulse_d;
    end
  end

endmodule

// File: tb/tb_start_sequencer.sv
// Randomized bench for start_sequencer against a cycle-count reference model.
module tb_start_sequencer;

  localparam int T = 4;
  localparam int G = 2;
  localparam int C = 3;
  localparam int TOTAL = C * T + G;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, game_over = 1'b0, pause = 1'b0;
  logic [3:0] STARTpos;
  logic       busy, game_active, go_pulse, step_pulse;

  int checks = 0;
  int failures = 0;

  // Reference model: countdown position as elapsed cycles since start.
  bit m_counting = 0, m_running = 0, m_go = 0;
  int m_t = 0;
  int m_code = 0, m_prev = 0;

  start_sequencer #(
    .TICKS_PER_STEP(T),
    .GO_TICKS      (G),
    .COUNT_FROM    (C)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .game_over  (game_over),
`ifdef START_SEQ_PAUSE_EN
    .pause      (pause),
`endif
    .STARTpos   (STARTpos),
    .busy       (busy),
    .game_active(game_active),
    .go_pulse   (go_pulse),
    .step_pulse (step_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int code_at(input int t);
    if (t < C * T) return C - t / T;
    return 15;
  endfunction

  task automatic model_reset();
    m_counting = 0; m_running = 0; m_go = 0; m_t = 0; m_code = 0; m_prev = 0;
  endtask

  task automatic model_step(input bit s, input bit a, input bit g, input bit p);
    bit was_running;
    bit paused;
    was_running = m_running;
`ifdef START_SEQ_PAUSE_EN
    paused = p;
`else
    paused = 0;
`endif
    if (a) begin
      m_counting = 0; m_running = 0;
    end else if (m_counting) begin
      if (!paused) begin
        m_t++;
        if (m_t == TOTAL) begin
          m_counting = 0; m_running = 1;
        end
      end
    end else if (m_running) begin
      if (g) m_running = 0;
    end else if (s) begin
      m_counting = 1; m_t = 0;
    end
    m_prev = m_code;
    m_code = m_counting ? code_at(m_t) : 0;
    m_go   = m_running && !was_running;
  endtask

  task automatic compare_all();
    check("STARTpos", 32'(STARTpos), 32'(m_code));
    check("busy", 32'(busy), 32'(m_counting));
    check("game_active", 32'(game_active), 32'(m_running));
    check("go_pulse", 32'(go_pulse), 32'(m_go));
    check("step_pulse", 32'(step_pulse), 32'((m_code != 0) && (m_code != m_prev)));
  endtask

  task automatic cyc(input bit s, input bit a, input bit g, input bit p);
    start = s; abort = a; game_over = g; pause = p;
    @(posedge clk);
    #1;
    model_step(s, a, g, p);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
  endtask

  initial begin
    int dur;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    #3 reset_n = 1'b1;

    idle(20);

    // Full countdown into RUN.
    cyc(1, 0, 0, 0);
    check("first_digit", 32'(STARTpos), 32'd3);
    idle(C * T + G);
    check("run_go_pulse", 32'(go_pulse), 32'd1);
    check("run_active", 32'(game_active), 32'd1);
    idle(3);
    cyc(0, 0, 1, 0);
    check("game_over_exit", 32'(game_active), 32'd0);
    idle(2);

    // Restart attempt during countdown is ignored.
    cyc(1, 0, 0, 0);
    idle(5);
    cyc(1, 0, 0, 0);
    idle(12);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 1, 0);

    // Abort mid-countdown, then fresh start; start+abort together.
    cyc(1, 0, 0, 0);
    idle(6);
    cyc(1, 1, 0, 0);
    check("abort_blank", 32'(STARTpos), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    idle(1);
    cyc(1, 0, 0, 0);
    check("restart_digit", 32'(STARTpos), 32'd3);
    idle(4);
    cyc(0, 1, 0, 0);
    idle(2);

    // Asynchronous reset while digit 2 is showing.
    cyc(1, 0, 0, 0);
    idle(T);
    check("pre_reset_digit", 32'(STARTpos), 32'd2);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_STARTpos", 32'(STARTpos), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    check("async_step", 32'(step_pulse), 32'd0);
    #2 reset_n = 1'b1;
    idle(5);

`ifdef START_SEQ_PAUSE_EN
    // Pause for three cycles while digit 2 is shown.
    cyc(1, 0, 0, 0);
    idle(T);
    dur = 1;
    cyc(0, 0, 0, 1); dur++;
    cyc(0, 0, 0, 1); dur++;
    cyc(0, 0, 0, 1); dur++;
    for (int i = 0; i < 20 && STARTpos == 4'd2; i++) begin
      cyc(0, 0, 0, 0);
      if (STARTpos == 4'd2) dur++;
    end
    check("pause_digit2_len", 32'(dur), 32'd7);
    cyc(0, 1, 0, 0);
`else
    dur = 0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 63) == 0),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/start_sequencer.md
Name: start_sequencer

Overview:
- Drives the 4-bit start-screen code consumed by the start-screen glyph mapper. Code meanings: 0 = blank, 1..3 = digit, any value ≥4 = "GO".
- Runs a timed 3-2-1-GO countdown when the player presses start, then hands control to gameplay by asserting game_active.
- Sits between the input debouncer/edge detector and the display pixel mux.

Parameters:
- TICKS_PER_STEP, 50_000_000, clock cycles each digit is displayed (1 s at 50 MHz); must be ≥1.
- GO_TICKS, 50_000_000, clock cycles "GO" is displayed; must be ≥1.
- COUNT_FROM, 3, first digit shown; legal range 1..3.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle start request (already edge-detected)
- abort  in  1  return to IDLE immediately
- game_over  in  1  gameplay ended; return to IDLE
- STARTpos  out  4  code to glyph mapper; registered
- busy  out  1  high during COUNT and GO
- game_active  out  1  high in RUN
- go_pulse  out  1  one-cycle pulse on entry to RUN
- step_pulse  out  1  one-cycle pulse whenever STARTpos changes to a new nonzero code

Behaviour:
- Reset values: STARTpos=0, busy=0, game_active=0, go_pulse=0, step_pulse=0, state=IDLE, tick counter=0.
- All outputs are registered and change only on a clk edge. Reset is the only asynchronous path.
- States: IDLE, COUNT, GO, RUN.
- IDLE: STARTpos=0. start=1 moves to COUNT; on the next cycle STARTpos=COUNT_FROM and step_pulse=1 (latency 1 cycle).
- COUNT: each digit is held exactly TICKS_PER_STEP cycles, then the digit decrements.
  - After digit 1 expires, go to GO: STARTpos=GO_CODE (4'hF), step_pulse=1.
- GO: held exactly GO_TICKS cycles, then go to RUN.
- RUN: STARTpos=0, game_active=1, go_pulse=1 on the first RUN cycle only. game_over=1 moves to IDLE next cycle with game_active=0.
- Total cycles from start edge to first RUN cycle: COUNT_FROM*TICKS_PER_STEP + GO_TICKS + 1.
- Tick counter:
  - Width is $clog2(max(TICKS_PER_STEP, GO_TICKS)+1).
  - Counts 0..N-1 and clears on every state or digit change.
  - No wrap-around beyond N-1 is observable.
- Priority, highest first: reset_n > abort > game_over > start.
  - abort in any state: IDLE next cycle, STARTpos=0, all pulses 0.
  - start together with abort: abort wins.
- start in COUNT/GO/RUN is ignored; no restart.
- game_over outside RUN is ignored.
- A reset asserted mid-countdown clears everything asynchronously. The next countdown begins only on a fresh start.
- TICKS_PER_STEP=1 is legal: each digit is held 1 cycle.

Optional Feature:
- Macro: START_SEQ_PAUSE_EN.
- Defined:
  - Adds input port pause (1 bit, placed after game_over).
  - While pause=1 in COUNT or GO, the tick counter and state freeze and STARTpos holds; pulses are suppressed.
  - pause has no effect in IDLE/RUN.
  - abort overrides pause.
- Undefined: no pause port; the countdown always free-runs.

Decomposition:
- Package start_pkg:
  - state enum (IDLE, COUNT, GO, RUN) as a 2-bit typedef
  - localparams BLANK_CODE=4'd0 and GO_CODE=4'hF
- Sub-module tick_counter:
  - Parameterised modulo counter with clear, enable and terminal-count pulse.
  - Instantiated once; enable is tied to the pause logic when the feature is compiled in.

Test Plan (TICKS_PER_STEP=4, GO_TICKS=2, COUNT_FROM=3):
- Reset then idle 20 cycles -> STARTpos=0, busy=0, game_active=0, no pulses.
- start at cycle 0 -> STARTpos=3 cycles 1-4, 2 cycles 5-8, 1 cycles 9-12, 15 cycles 13-14. At cycle 15: STARTpos=0, game_active=1, go_pulse=1 for one cycle. step_pulse at cycles 1, 5, 9, 13.
- start again at cycle 6 during countdown -> sequence unchanged from the previous case.
- abort at cycle 7 -> cycle 8: STARTpos=0, busy=0. A new start at cycle 10 -> STARTpos=3 at cycle 11.
- In RUN, assert game_over -> next cycle game_active=0, state IDLE. start then restarts the countdown with STARTpos=3.
- reset_n low asynchronously mid-cycle at STARTpos=2 -> outputs 0 immediately, before the next clk edge. With START_SEQ_PAUSE_EN: pause held 3 cycles during digit 2 -> digit 2 lasts 7 cycles.
